// File: rtl/msi_snoop_bus_pkg.sv
// msi_snoop_bus_pkg
// Shared types and constants for the MSI snoop bus and the per-core cache
// controllers that sit upstream of it.
//   bus_state_t : bus FSM state encoding
//   bus_req_t   : captured request type
//   SOURCE_*    : cpu_datasel encodings (fill source)
//   req_decode  : per-core request priority encoder
package msi_snoop_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    MEM   = 3'd2,
    INVAL = 3'd3,
    DONE  = 3'd4
  } bus_state_t;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_INV  = 3'd1,
    REQ_WM   = 3'd2,
    REQ_RM   = 3'd3,
    REQ_UW   = 3'd4,
    REQ_UR   = 3'd5
  } bus_req_t;

  localparam logic [1:0] SOURCE_DMEM       = 2'b00;
  localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

  // Priority when several request types arrive from one core together:
  // invalidate > write_miss > read_miss > u_we > u_re.
  function automatic bus_req_t req_decode(input logic inv, input logic wm,
                                          input logic rm, input logic uw,
                                          input logic ur);
    bus_req_t t;
    if (inv)     t = REQ_INV;
    else if (wm) t = REQ_WM;
    else if (rm) t = REQ_RM;
    else if (uw) t = REQ_UW;
    else if (ur) t = REQ_UR;
    else         t = REQ_NONE;
    return t;
  endfunction

endpackage

// File: rtl/msi_snoop_bus_rr_arbiter.sv
// bus_rr_arbiter
// Two-requester round-robin arbiter with a per-core pending latch.
// A core's request type and address are captured on the first request cycle
// and held until the bus signals DONE for that core; further requests from a
// pending core are ignored. The winner view merges latched and incoming
// requests so an idle bus can start a transaction in the request cycle.
// Ports:
//   i_req_v[1:0]        incoming request present per core
//   i_type0/1, i_addr0/1 incoming request type and word address per core
//   i_done, i_done_core  bus finished the transaction of core i_done_core
//   o_pending[1:0]      latched pending flags
//   o_win_v, o_win      some core requesting / index of the winner
//   o_win_type/addr     type and address of the winner
//   o_rr_ptr            round-robin pointer (core favoured on a tie)
module bus_rr_arbiter
  import msi_snoop_bus_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_req_v,
  input  bus_req_t          i_type0,
  input  bus_req_t          i_type1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_done,
  input  logic              i_done_core,
  output logic [1:0]        o_pending,
  output logic              o_win_v,
  output logic              o_win,
  output bus_req_t          o_win_type,
  output logic [ADDR_W-1:0] o_win_addr,
  output logic              o_rr_ptr
);

  logic [1:0]        r_pending;
  bus_req_t          r_type [2];
  logic [ADDR_W-1:0] r_addr [2];
  logic              r_rr;

  logic [1:0]        w_v;
  bus_req_t          w_in_type [2];
  logic [ADDR_W-1:0] w_in_addr [2];
  bus_req_t          w_type [2];
  logic [ADDR_W-1:0] w_addr [2];

  always_comb begin
    w_in_type[0] = i_type0;
    w_in_type[1] = i_type1;
    w_in_addr[0] = i_addr0;
    w_in_addr[1] = i_addr1;
    w_v = r_pending | i_req_v;
    for (int i = 0; i < 2; i++) begin
      w_type[i] = r_pending[i] ? r_type[i] : w_in_type[i];
      w_addr[i] = r_pending[i] ? r_addr[i] : w_in_addr[i];
    end
    o_win_v    = |w_v;
    // Tie goes to rr_ptr; a lone requester wins outright.
    o_win      = (w_v == 2'b11) ? r_rr : w_v[1];
    o_win_type = o_win ? w_type[1] : w_type[0];
    o_win_addr = o_win ? w_addr[1] : w_addr[0];
    o_pending  = r_pending;
    o_rr_ptr   = r_rr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 2'b00;
      r_rr      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_type[i] <= REQ_NONE;
        r_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i_done && (i_done_core == 1'(i))) begin
          r_pending[i] <= 1'b0;
        end else if (!r_pending[i] && i_req_v[i]) begin
          r_pending[i] <= 1'b1;
          r_type[i]    <= w_in_type[i];
          r_addr[i]    <= w_in_addr[i];
        end
      end
      if (i_done) r_rr <= ~i_done_core;
    end
  end

endmodule

// File: rtl/msi_snoop_bus.sv
// msi_snoop_bus
// Coherence bus shared by two MSI cache controllers and one unified memory.
// Captures miss/invalidate/memory requests, arbitrates round-robin, snoops
// the non-owner cache and muxes the owner's memory request onto the port.
// Optional build macro SNOOP_BUS_TIMEOUT_EN adds a memory-wait timeout and
// the o_bus_err output.
// Ports:
//   i_read_miss/i_write_miss/i_invalidate [1:0]  per-core request pulses
//   i_u_re/i_u_we [1:0]                          per-core memory strobes
//   i_bico0/1, i_u_addr0/1, i_d_line0/1          per-core address/data
//   i_cpu_search_found [1:0], i_send_other_proc_data0/1  snoop response
//   i_mem_rdy, i_mem_rd_data                     memory response
//   o_grant, o_cpu_search, o_boci, o_invalidate_from_other_cpu,
//   o_cpu_datasel0/1, o_other_proc_data, o_u_rdy, o_u_rd_data  to caches
//   o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata  memory port
//   o_bus_err (SNOOP_BUS_TIMEOUT_EN only)         one-cycle timeout pulse
module msi_snoop_bus
  import msi_snoop_bus_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int UADDR_W = 11,
  parameter int LINE_W  = 64,
  parameter int WORD_W  = 16,
  parameter int TO_CYC  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_read_miss,
  input  logic [1:0]         i_write_miss,
  input  logic [1:0]         i_invalidate,
  input  logic [1:0]         i_u_re,
  input  logic [1:0]         i_u_we,
  input  logic [ADDR_W-1:0]  i_bico0,
  input  logic [ADDR_W-1:0]  i_bico1,
  input  logic [UADDR_W-1:0] i_u_addr0,
  input  logic [UADDR_W-1:0] i_u_addr1,
  input  logic [LINE_W-1:0]  i_d_line0,
  input  logic [LINE_W-1:0]  i_d_line1,
  input  logic [1:0]         i_cpu_search_found,
  input  logic [WORD_W-1:0]  i_send_other_proc_data0,
  input  logic [WORD_W-1:0]  i_send_other_proc_data1,
  input  logic               i_mem_rdy,
  input  logic [LINE_W-1:0]  i_mem_rd_data,
`ifdef SNOOP_BUS_TIMEOUT_EN
  output logic               o_bus_err,
`endif
  output logic [1:0]         o_grant,
  output logic [1:0]         o_cpu_search,
  output logic [ADDR_W-1:0]  o_boci,
  output logic [1:0]         o_invalidate_from_other_cpu,
  output logic [1:0]         o_cpu_datasel0,
  output logic [1:0]         o_cpu_datasel1,
  output logic [WORD_W-1:0]  o_other_proc_data,
  output logic [1:0]         o_u_rdy,
  output logic [LINE_W-1:0]  o_u_rd_data,
  output logic               o_mem_re,
  output logic               o_mem_we,
  output logic [UADDR_W-1:0] o_mem_addr,
  output logic [LINE_W-1:0]  o_mem_wdata
);

  bus_state_t        r_state;
  logic              r_owner;
  bus_req_t          r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_sel;
  logic [WORD_W-1:0] r_opd;
  logic              r_seen_rdy;
`ifdef SNOOP_BUS_TIMEOUT_EN
  logic [7:0]        r_to_cnt;
  logic              r_bus_err;
`endif

  logic              w_other;
  bus_req_t          w_type0, w_type1;
  logic [1:0]        w_req_v;
  logic [1:0]        w_pending;
  logic              w_win_v, w_win, w_rr_ptr;
  bus_req_t          w_win_type;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_found;
  logic [WORD_W-1:0] w_snoop_word;
  logic              w_own_strobe;
  logic [1:0]        w_sel [2];

  assign w_other      = ~r_owner;
  assign w_type0      = req_decode(i_invalidate[0], i_write_miss[0],
                                   i_read_miss[0], i_u_we[0], i_u_re[0]);
  assign w_type1      = req_decode(i_invalidate[1], i_write_miss[1],
                                   i_read_miss[1], i_u_we[1], i_u_re[1]);
  assign w_req_v      = {w_type1 != REQ_NONE, w_type0 != REQ_NONE};
  assign w_found      = i_cpu_search_found[w_other];
  assign w_snoop_word = w_other ? i_send_other_proc_data1
                                : i_send_other_proc_data0;
  assign w_own_strobe = i_u_re[r_owner] | i_u_we[r_owner];

  bus_rr_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req_v    (w_req_v),
    .i_type0    (w_type0),
    .i_type1    (w_type1),
    .i_addr0    (i_bico0),
    .i_addr1    (i_bico1),
    .i_done     (r_state == DONE),
    .i_done_core(r_owner),
    .o_pending  (w_pending),
    .o_win_v    (w_win_v),
    .o_win      (w_win),
    .o_win_type (w_win_type),
    .o_win_addr (w_win_addr),
    .o_rr_ptr   (w_rr_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_type     <= REQ_NONE;
      r_addr     <= '0;
      r_sel      <= SOURCE_DMEM;
      r_opd      <= '0;
      r_seen_rdy <= 1'b0;
`ifdef SNOOP_BUS_TIMEOUT_EN
      r_to_cnt   <= 8'd0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
`ifdef SNOOP_BUS_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_sel      <= SOURCE_DMEM;
          r_opd      <= '0;
          r_seen_rdy <= 1'b0;
`ifdef SNOOP_BUS_TIMEOUT_EN
          r_to_cnt   <= 8'd0;
`endif
          if (w_win_v) begin
            r_owner <= w_win;
            r_type  <= w_win_type;
            r_addr  <= w_win_addr;
            case (w_win_type)
              REQ_INV:         r_state <= INVAL;
              REQ_WM, REQ_RM:  r_state <= SNOOP;
              REQ_UW, REQ_UR:  r_state <= MEM;
              default:         r_state <= IDLE;
            endcase
          end
        end
        SNOOP: begin
          if (w_found) begin
            r_sel   <= SOURCE_OTHER_PROC;
            r_opd   <= w_snoop_word;
            r_state <= DONE;
          end else begin
            r_sel   <= SOURCE_DMEM;
            r_state <= MEM;
          end
        end
        MEM: begin
          // r_seen_rdy survives only until the owner raises its next strobe,
          // so evict-then-fill stays a single transaction.
          if (i_mem_rdy)         r_seen_rdy <= 1'b1;
          else if (w_own_strobe) r_seen_rdy <= 1'b0;
`ifdef SNOOP_BUS_TIMEOUT_EN
          r_to_cnt <= i_mem_rdy ? 8'd0 : r_to_cnt + 8'd1;
`endif
          if (r_seen_rdy && !w_own_strobe) begin
            r_state <= DONE;
          end
`ifdef SNOOP_BUS_TIMEOUT_EN
          else if (!i_mem_rdy && (r_to_cnt == 8'(TO_CYC - 1))) begin
            r_state   <= DONE;
            r_bus_err <= 1'b1;
          end
`endif
        end
        INVAL: r_state <= DONE;
        DONE: begin
          r_state <= IDLE;
          r_sel   <= SOURCE_DMEM;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_grant                     = 2'b00;
    o_cpu_search                = 2'b00;
    o_boci                      = '0;
    o_invalidate_from_other_cpu = 2'b00;
    o_other_proc_data           = '0;
    o_u_rdy                     = 2'b00;
    o_mem_re                    = 1'b0;
    o_mem_we                    = 1'b0;
    o_mem_addr                  = '0;
    o_mem_wdata                 = '0;
    w_sel[0]                    = SOURCE_DMEM;
    w_sel[1]                    = SOURCE_DMEM;
    case (r_state)
      SNOOP: begin
        o_cpu_search[w_other] = 1'b1;
        o_boci                = r_addr;
        if (w_found) begin
          o_other_proc_data = w_snoop_word;
          w_sel[r_owner]    = SOURCE_OTHER_PROC;
          if (r_type == REQ_WM) o_invalidate_from_other_cpu[w_other] = 1'b1;
        end
      end
      MEM: begin
        o_grant[r_owner] = 1'b1;
        o_mem_re         = i_u_re[r_owner];
        o_mem_we         = i_u_we[r_owner];
        o_mem_addr       = r_owner ? i_u_addr1 : i_u_addr0;
        o_mem_wdata      = r_owner ? i_d_line1 : i_d_line0;
        o_u_rdy[r_owner] = i_mem_rdy;
        w_sel[r_owner]   = r_sel;
      end
      INVAL: begin
        o_invalidate_from_other_cpu[w_other] = 1'b1;
        o_boci                               = r_addr;
      end
      DONE: begin
        w_sel[r_owner]    = r_sel;
        o_other_proc_data = r_opd;
      end
      default: ;
    endcase
  end

  assign o_cpu_datasel0 = w_sel[0];
  assign o_cpu_datasel1 = w_sel[1];
  assign o_u_rd_data    = i_mem_rd_data;
`ifdef SNOOP_BUS_TIMEOUT_EN
  assign o_bus_err      = r_bus_err;
`endif

endmodule

// File: doc/msi_snoop_bus.md
Name: msi_snoop_bus

Overview:
- Shared coherence bus between the two per-core cache controllers and unified data memory; directly downstream of each cache controller.
- Captures miss/invalidate/memory requests, arbitrates round-robin, and runs the snoop of the other core's cache.
- Drives cpu_search/BOCI/invalidate_from_other_cpu/cpu_datasel/other_proc_data/grant back into the controllers.
- Muxes the granted core's unified-memory request onto the single memory port.

Parameters:
- ADDR_W, 13, word address width (BICO/BOCI)
- UADDR_W, 11, line address width (u_addr)
- LINE_W, 64, cache line width
- WORD_W, 16, data word width
- TO_CYC, 255, memory-wait timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- read_miss  in  [1:0]  per-core read-miss pulse
- write_miss  in  [1:0]  per-core write-miss pulse
- invalidate  in  [1:0]  per-core invalidate pulse (write hit on SHARED)
- u_re, u_we  in  [1:0]  per-core memory read/write request (level)
- BICO0, BICO1  in  ADDR_W  per-core requesting word address
- u_addr0, u_addr1  in  UADDR_W  per-core memory line address
- d_line0, d_line1  in  LINE_W  per-core eviction data
- cpu_search_found  in  [1:0]  per-core snoop hit, combinational in the same cycle as cpu_search
- send_other_proc_data0, send_other_proc_data1  in  WORD_W  per-core snoop word
- mem_rdy  in  1  memory done
- mem_rd_data  in  LINE_W  memory read line
- grant  out  [1:0]  one-hot owner grant
- cpu_search  out  [1:0]  snoop strobe to the non-owner
- BOCI  out  ADDR_W  snoop/invalidate address (latched owner address)
- invalidate_from_other_cpu  out  [1:0]  invalidate strobe to the non-owner
- cpu_datasel0, cpu_datasel1  out  2  fill source: 00 = DMEM, 01 = other processor
- other_proc_data  out  WORD_W  snooped word, routed to the owner
- u_rdy  out  [1:0]  mem_rdy gated by grant
- u_rd_data  out  LINE_W  mem_rd_data broadcast to both cores
- mem_re, mem_we  out  1  memory strobes
- mem_addr  out  UADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write line

Behaviour:
- Reset: state=IDLE, pending=0, rr_ptr=0. All outputs 0, except cpu_datasel=00 and BOCI=0.
- pending[i] records the request type. Priority when several types arrive together: invalidate > write_miss > read_miss > u_we > u_re. pending[i] sets on any request cycle and holds until DONE for that core. A new pulse from a core already pending is ignored.
- pending also latches the core's BICO; the latched address is used for the whole transaction.
- IDLE:
  - If both cores are pending, the winner is core rr_ptr; otherwise the winner is the single pending core.
  - Latch owner, type, and addr.
  - Next state: invalidate -> INVAL; read_miss/write_miss -> SNOOP; u_re/u_we -> MEM.
  - No pending -> stay in IDLE.
- SNOOP, 1 cycle:
  - cpu_search[other]=1, BOCI=addr.
  - If found: other_proc_data=send_other_proc_data[other], cpu_datasel[owner]=01, -> DONE. On a write_miss, additionally assert invalidate_from_other_cpu[other]=1 in this same cycle.
  - If not found: cpu_datasel[owner]=00, -> MEM.
- MEM:
  - grant[owner]=1; mem_re/mem_we follow the owner's u_re/u_we.
  - mem_addr/mem_wdata are muxed from the owner.
  - u_rdy[owner]=mem_rdy.
  - Stay in MEM until mem_rdy & (owner u_re|u_we) = 0 after the last handshake. Exit to DONE in the cycle after mem_rdy if the owner has dropped both strobes. Evict-then-fill (u_we then u_re) is one transaction.
- INVAL, 1 cycle: invalidate_from_other_cpu[other]=1, BOCI=addr, -> DONE.
- DONE, 1 cycle: clear pending[owner], rr_ptr = ~owner, -> IDLE.
- cpu_datasel[owner] holds its value from SNOOP until DONE; otherwise it is 00.
- Simultaneous requests to the same line: the first winner completes first. The second core's snoop then sees the updated state.
- Reset asserted in any state returns to the reset values on the next edge; any in-flight memory access is dropped.
- Latency: the best-case snoop hit takes 3 cycles, request through DONE.

Optional Feature:
- Macro: SNOOP_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in MEM and clears on any mem_rdy.
  - On reaching TO_CYC: force DONE, pulse bus_err (extra output, 1 bit, 1 cycle), and drop grant.
- Undefined: no counter and no bus_err port; MEM waits indefinitely.

Decomposition:
- In the common package: typedef enum bus_state_t {IDLE,SNOOP,MEM,INVAL,DONE}, typedef enum bus_req_t {REQ_NONE,REQ_INV,REQ_WM,REQ_RM,REQ_UW,REQ_UR}, and localparams SOURCE_DMEM=2'b00 and SOURCE_OTHER_PROC=2'b01. The cache controller then uses these shared constants.
- One sub-module, bus_rr_arbiter: 2-requester round-robin with pending latch, rr_ptr, and winner output.

Test Plan:
- Core0 read_miss at BICO0=13'h0104, cpu_search_found[1]=1, send_other_proc_data1=16'hBEEF -> next cycle cpu_search[1]=1 and BOCI=13'h0104; other_proc_data=16'hBEEF and cpu_datasel0=01; DONE, and grant never asserted.
- Core1 write_miss at 13'h0200, no snoop hit, mem_rdy after 4 cycles -> cpu_datasel1=00, grant=2'b10, mem_re=1, mem_addr=11'h080; IDLE after DONE.
- Same-cycle read_miss from both cores after reset -> core0 served first, then core1; rr_ptr=0 after the second DONE.
- Core0 invalidate at 13'h0031 -> exactly one cycle of invalidate_from_other_cpu=2'b10 with BOCI=13'h0031.
- Core0 u_we then u_re, with rst pulsed mid-MEM -> all outputs return to 0 the next cycle and pending=0.
- With SNOOP_BUS_TIMEOUT_EN, mem_rdy held low for 255 cycles -> bus_err pulses once, grant drops, and core1's queued request is then served.
